fetch_queue_unit: RTL

- Parametrised instruction-fetch front end for the next-generation datapath; replaces the single-cycle PC register plus PC+4 adder path.
- Owns the fetch PC and issues requests to a synchronous instruction memory with one-cycle latency.
- Buffers returned instructions in a DEPTH-entry FIFO; the decode stage consumes them with a valid/ready handshake.
- Accepts branch/jump redirects that flush all buffered and in-flight fetches.

---
 rtl/fetch_queue_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end with request issue, response FIFO and redirect flush
//
// Owns the fetch PC, issues one request per cycle to a one-cycle-latency
// instruction memory while a FIFO slot is reserved for it, buffers the
// returned words with their PCs and hands them to decode via valid/ready.
// A redirect flushes buffered entries and discards the in-flight response.
//
// Optional feature macro: FETCH_PERF_EN (adds redirect/flush counters).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   o_imem_req, o_imem_addr fetch request and its byte address (= o_fetch_pc)
//   i_imem_valid, i_imem_rdata  memory response, one cycle after request
//   i_redirect_valid, i_redirect_pc  flush and reload fetch PC
//   o_inst_valid, i_inst_ready, o_inst, o_inst_pc  head of FIFO to decode
//   o_fetch_pc              next address to fetch
//   o_count                 occupied FIFO entries
//   o_perf_redirects, o_perf_flushed  (FETCH_PERF_EN only) saturating counters

module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_imem_req,
    output logic [XLEN-1:0]            o_imem_addr,
    input  logic                       i_imem_valid,
    input  logic [INST_W-1:0]          i_imem_rdata,
    input  logic                       i_redirect_valid,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic                       o_inst_valid,
    input  logic                       i_inst_ready,
    output logic [INST_W-1:0]          o_inst,
    output logic [XLEN-1:0]            o_inst_pc,
    output logic [XLEN-1:0]            o_fetch_pc,
    output logic [$clog2(DEPTH):0]     o_count
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]                o_perf_redirects,
    output logic [15:0]                o_perf_flushed
`endif
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW+1:0]   W_DEPTH  = (AW+2)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_M  = ~(XLEN'(3));

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_req_addr;
    logic              r_inflight;
    logic              r_drop_next;
    logic [AW:0]       r_count;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [XLEN-1:0]   r_mem_pc   [DEPTH];

    logic [AW+1:0]     w_occ;
    logic              w_req;
    logic              w_inst_valid;
    logic              w_push;
    logic              w_pop;

    // Occupancy includes the slot reserved for the outstanding request, so a
    // response can always be written without checking for a full FIFO.
    assign w_occ        = {1'b0, r_count} + (AW+2)'(r_inflight);
    assign w_req        = !i_rst && !i_redirect_valid && (w_occ < W_DEPTH);
    assign w_inst_valid = (r_count != '0);
    assign w_push       = i_imem_valid && r_inflight && !r_drop_next;
    assign w_pop        = w_inst_valid && i_inst_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc  <= RESET_PC & ALIGN_M;
            r_req_addr  <= '0;
            r_inflight  <= 1'b0;
            r_drop_next <= 1'b0;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
        end else if (i_redirect_valid) begin
            r_fetch_pc  <= i_redirect_pc & ALIGN_M;
            r_inflight  <= 1'b0;
            r_drop_next <= r_inflight;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
        end else begin
            r_inflight  <= w_req;
            r_drop_next <= 1'b0;
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_req_addr <= r_fetch_pc;
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; reads are masked by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst && !i_redirect_valid) begin
            r_mem_inst[r_tail] <= i_imem_rdata;
            r_mem_pc[r_tail]   <= r_req_addr;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_redirects;
    logic [15:0] r_perf_flushed;
    logic [16:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_perf_flushed} + 17'(w_occ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_redirects <= '0;
            r_perf_flushed   <= '0;
        end else if (i_redirect_valid) begin
            if (r_perf_redirects != 16'hFFFF) begin
                r_perf_redirects <= r_perf_redirects + 16'd1;
            end
            r_perf_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end

    assign o_perf_redirects = r_perf_redirects;
    assign o_perf_flushed   = r_perf_flushed;
`endif

    assign o_imem_req   = w_req;
    assign o_imem_addr  = r_fetch_pc;
    assign o_fetch_pc   = r_fetch_pc;
    assign o_count      = r_count;
    assign o_inst_valid = w_inst_valid;
    assign o_inst       = w_inst_valid ? r_mem_inst[r_head] : '0;
    assign o_inst_pc    = w_inst_valid ? r_mem_pc[r_head]   : '0;

endmodule
